data_mem_arbiter: RTL

//  Shares the single-port data memory between the pipeline MEM stage (cpu) and an external

---
 rtl/data_mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: the MEM stage (cpu) has priority; external bursts
// fill idle cycles and, when starved for MAX_WAIT cycles, steal one cycle by stalling the cpu.
module data_mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int LEN_W    = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cpu_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [AW-1:0]    ext_addr,
  input  logic [LEN_W-1:0] ext_len,
  input  logic [DW-1:0]    ext_wdata,
  output logic             ext_ack,
  output logic [DW-1:0]    ext_rdata,
  output logic             ext_rvalid,
  output logic             ext_done,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FORCE
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_idx_q, beat_idx_d;
  logic             we_q, we_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             cpu_stall_q, cpu_stall_d;
  logic [DW-1:0]    ext_rdata_q, ext_rdata_d;
  logic             ext_rvalid_q, ext_rvalid_d;
  logic             ext_done_q, ext_done_d;

  logic             cpu_active;
  logic             beat;
  logic [AW-1:0]    beat_addr;

  assign cpu_active = cpu_rd | cpu_wr;
  // In FORCE the pipeline is frozen, so whatever cpu_rd/cpu_wr show is a replay and is ignored.
  assign beat       = (state_q == FORCE) | ((state_q == BURST) & ~cpu_active);
  assign beat_addr  = base_q + AW'(beat_idx_q);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    len_d        = len_q;
    beat_idx_d   = beat_idx_q;
    we_d         = we_q;
    wait_cnt_d   = wait_cnt_q;
    cpu_stall_d  = 1'b0;
    ext_rdata_d  = ext_rdata_q;
    ext_rvalid_d = 1'b0;
    ext_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ext_req) begin
          base_d     = ext_addr;
          len_d      = ext_len;
          we_d       = ext_we;
          beat_idx_d = '0;
          wait_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST, FORCE: begin
        if (beat) begin
          wait_cnt_d = '0;
          if (!we_q) begin
            ext_rvalid_d = 1'b1;
            ext_rdata_d  = mem_rdata;
          end
          if (beat_idx_q == len_q) begin
            ext_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            beat_idx_d = beat_idx_q + LEN_W'(1);
            state_d    = BURST;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
          if (wait_cnt_d == WCW'(MAX_WAIT)) begin
            state_d     = FORCE;
            cpu_stall_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      beat_idx_q   <= '0;
      we_q         <= 1'b0;
      wait_cnt_q   <= '0;
      cpu_stall_q  <= 1'b0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
      ext_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      beat_idx_q   <= beat_idx_d;
      we_q         <= we_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_stall_q  <= cpu_stall_d;
      ext_rdata_q  <= ext_rdata_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_done_q   <= ext_done_d;
    end
  end

  // Memory port: the ext beat owns it exactly in ack cycles, otherwise the cpu path passes through.
  always_comb begin
    if (beat) begin
      mem_addr  = beat_addr;
      mem_wdata = ext_wdata;
      mem_rd    = ~we_q;
      mem_wr    = we_q;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_stall_q;
  assign ext_ack    = beat;
  assign ext_rdata  = ext_rdata_q;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_done   = ext_done_q;

endmodule
